// File: rtl/ins_enc_pkg.sv
// Shared type codes, opcodes and FIFO entry layout for the instruction encoder.
package ins_enc_pkg;

  typedef enum logic [1:0] {
    TYPE_LD  = 2'b00,
    TYPE_SD  = 2'b01,
    TYPE_ILL = 2'b10,
    TYPE_BR  = 2'b11
  } ins_type_e;

  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_SD = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  // Address field is sized for the widest supported counter; the top uses the low ADDR_W bits.
  localparam int unsigned ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             ins;
  } enc_entry_t;

  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

endpackage

// File: rtl/ins_enc_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two.
module ins_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ins_encoder.sv
// Packs ld/sd/br requests into instruction words and streams them with word addresses.
// Optional re-decode self-check enabled by defining ENC_SELF_CHECK_EN.
module ins_encoder
  import ins_enc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              chk_fail
);

  logic [31:0]       word;
  logic              type_ok, imm_ok, reject, accept, push;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              full, empty;
  enc_entry_t        wdata, rdata;
  logic [ENTRY_ADDR_W-1:0] addr_ext;
  logic              unused_addr;
  logic [11:0]       b;

  assign b = in_imm[11:0];

  always_comb begin
    word    = '0;
    type_ok = 1'b1;
    case (ins_type_e'(in_type))
      TYPE_LD: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LD};
      TYPE_SD: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_SD};
      TYPE_BR: word = {b[11], b[9:4], in_rs2, in_rs1, in_funct3, b[3:0], b[10], OPC_BR};
      default: type_ok = 1'b0;
    endcase
  end

  assign imm_ok   = (&in_imm[63:11]) || !(|in_imm[63:11]);
  assign reject   = !(type_ok && imm_ok);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !reject;
  assign wdata    = '{addr: ENTRY_ADDR_W'(addr_q), ins: word};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= ADDR_W'(BASE_ADDR);
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && reject;
      if (push) addr_q <= addr_q + 1'b1;
    end
  end

  ins_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(enc_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (out_valid && out_ready),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Stale storage is masked so the outputs read zero whenever nothing is buffered.
  assign out_valid   = !empty;
  assign out_ins     = empty ? 32'h0 : rdata.ins;
  assign addr_ext    = empty ? '0 : rdata.addr;
  assign out_addr    = addr_ext[ADDR_W-1:0];
  assign unused_addr = ^(addr_ext >> ADDR_W);
  assign err         = err_q;

`ifdef ENC_SELF_CHECK_EN
  logic [63:0] dec_imm;
  logic        chk_q;

  always_comb begin
    dec_imm = in_imm;
    case (word[6:0])
      OPC_LD:  dec_imm = sext12(word[31:20]);
      OPC_SD:  dec_imm = sext12({word[31:25], word[11:7]});
      OPC_BR:  dec_imm = sext12({word[31], word[7], word[30:25], word[11:8]});
      default: dec_imm = in_imm;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_q <= 1'b0;
    end else if (push && (dec_imm != in_imm)) begin
      chk_q <= 1'b1;
    end
  end

  assign chk_fail = chk_q;
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_ins_encoder.sv
// Table-driven bench with a scoreboard for two encoder instances sharing one stimulus stream.
module tb_ins_encoder;

  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [31:0] ins;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_type = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_imm = '0;
  logic        out_ready = 1'b1;

  logic        in_ready1, out_valid1, err1, chk_fail1;
  logic [31:0] out_ins1;
  logic [7:0]  out_addr1;
  logic        in_ready2, out_valid2, err2, chk_fail2;
  logic [31:0] out_ins2;
  logic [1:0]  out_addr2;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q1[$];
  exp_t q2[$];
  logic [7:0] addr1 = 8'd0;
  logic [1:0] addr2 = 2'd0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  ins_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_type   (in_type),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_ins   (out_ins1),
    .out_addr  (out_addr1),
    .err       (err1),
    .chk_fail  (chk_fail1)
  );

  ins_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_type   (in_type),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_ins   (out_ins2),
    .out_addr  (out_addr2),
    .err       (err2),
    .chk_fail  (chk_fail2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: compare the head word whenever a pop will happen on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid1 && out_ready) begin
      if (q1.size() == 0) check("dut1_unexpected_word", {32'h0, out_ins1}, 64'h0);
      else begin
        e = q1.pop_front();
        check("dut1_ins", {32'h0, out_ins1}, {32'h0, e.ins});
        check("dut1_addr", {56'h0, out_addr1}, {56'h0, e.addr});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid2 && out_ready) begin
      if (q2.size() == 0) check("dut2_unexpected_word", {32'h0, out_ins2}, 64'h0);
      else begin
        e = q2.pop_front();
        check("dut2_ins", {32'h0, out_ins2}, {32'h0, e.ins});
        check("dut2_addr", {62'h0, out_addr2}, {56'h0, e.addr});
      end
    end
  end

  task automatic send(input vec_t v, input bit expect_empty);
    int g;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_type   = v.typ;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_imm    = v.imm;
    g = 0;
    while (!in_ready1 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!in_ready1) begin
      check("in_ready_timeout", 64'h0, 64'h1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (expect_empty) check("no_bypass_out_valid", {63'h0, out_valid1}, 64'h0);
    @(posedge clk);
    if (!v.err) begin
      e.ins = v.ins;
      e.addr = addr1;
      q1.push_back(e);
      e.addr = {6'h0, addr2};
      q2.push_back(e);
      addr1 = addr1 + 8'd1;
      addr2 = addr2 + 2'd1;
    end
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", {62'h0, err1, err2}, {62'h0, v.err, v.err});
    if (!v.err) check("out_valid_after_accept", {63'h0, out_valid1}, 64'h1);
    @(negedge clk);
    check("err_drop", {62'h0, err1, err2}, 64'h0);
  endtask

  task automatic drain();
    int g = 0;
    while ((q1.size() != 0 || q2.size() != 0) && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("drain_left", 64'(q1.size() + q2.size()), 64'h0);
  endtask

  initial begin
    int legal[6] = '{0, 1, 2, 5, 6, 7};

    vecs[0] = '{2'b00, 5'd5, 5'd2, 5'd12, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFF813283, 1'b0};
    vecs[1] = '{2'b01, 5'd9, 5'd3, 5'd7,  3'd3, 64'd16,                  32'h0071B823, 1'b0};
    vecs[2] = '{2'b11, 5'd3, 5'd1, 5'd2,  3'd0, 64'd4,                   32'h00208463, 1'b0};
    vecs[3] = '{2'b00, 5'd5, 5'd2, 5'd0,  3'd3, 64'd2048,                32'h0,        1'b1};
    vecs[4] = '{2'b10, 5'd1, 5'd1, 5'd1,  3'd0, 64'd0,                   32'h0,        1'b1};
    vecs[5] = '{2'b00, 5'd1, 5'd0, 5'd0,  3'd2, 64'd2047,                32'h7FF02083, 1'b0};
    vecs[6] = '{2'b01, 5'd0, 5'd31, 5'd31, 3'd7, 64'hFFFF_FFFF_FFFF_F800, 32'h81FFF023, 1'b0};
    vecs[7] = '{2'b11, 5'd0, 5'd5, 5'd6,  3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE629EE3, 1'b0};
    vecs[8] = '{2'b00, 5'd1, 5'd1, 5'd0,  3'd0, 64'hFFFF_FFFF_FFFF_F7FF, 32'h0,        1'b1};
    vecs[9] = '{2'b01, 5'd1, 5'd1, 5'd1,  3'd0, 64'h8000_0000_0000_0000, 32'h0,        1'b1};

    #12;
    check("rst_out_valid", {62'h0, out_valid1, out_valid2}, 64'h0);
    check("rst_out_ins", {out_ins1, out_ins2}, 64'h0);
    check("rst_out_addr", {54'h0, out_addr1, out_addr2}, 64'h0);
    check("rst_err_chk", {60'h0, err1, err2, chk_fail1, chk_fail2}, 64'h0);
    check("rst_in_ready", {62'h0, in_ready1, in_ready2}, 64'h3);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // One request at a time with the consumer always ready.
    for (int i = 0; i < 10; i++) send(vecs[i], 1'b1);
    drain();

    // Backpressure: four fill the FIFO, the rest wait for the consumer.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[legal[i]], 1'b0);
    @(negedge clk);
    check("full_in_ready", {62'h0, in_ready1, in_ready2}, 64'h0);
    fork
      begin
        send(vecs[legal[4]], 1'b0);
        send(vecs[legal[5]], 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with words buffered flushes them and restarts the address at BASE_ADDR.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[legal[i]], 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", {62'h0, out_valid1, out_valid2}, 64'h0);
    check("midrst_out_addr", {54'h0, out_addr1, out_addr2}, 64'h0);
    q1.delete();
    q2.delete();
    addr1 = 8'd0;
    addr2 = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send(vecs[5], 1'b1);
    drain();

    check("chk_fail_final", {62'h0, chk_fail1, chk_fail2}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_encoder.md
Name: ins_encoder

Overview:
- Inverse of the immediate decode path. Packs load/store/branch requests (type, registers, funct3, 64-bit immediate) into 32-bit instruction words.
- Buffers the encoded words in a small FIFO and streams them, each with a sequential word address, to the instruction-memory write port.
- Used as the test-program loader ahead of the fetch path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 8, width of the word-address counter
- BASE_ADDR, 0, address given to the first word after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted on the edge where in_valid & in_ready
- in_type  in  2  00 ld, 01 sd, 11 br, 10 illegal
- in_rd  in  5  destination register (ld only)
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (sd, br)
- in_funct3  in  3  funct3 field
- in_imm  in  64  immediate; br value is in halfword units
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts on the edge where out_valid & out_ready
- out_ins  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_ins
- err  out  1  one-cycle pulse on a rejected request
- chk_fail  out  1  sticky self-check flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): FIFO empty; out_valid=0, out_ins=0, out_addr=0, err=0, chk_fail=0; address counter=BASE_ADDR. in_ready=1, since it is combinationally !full.
- Encode (combinational, captured into the FIFO at accept):
  - ld: {imm[11:0], rs1, funct3, rd, 7'b0000011}
  - sd: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - br, with b=imm[11:0]: {b[11], b[9:4], rs2, rs1, funct3, b[3:0], b[10], 7'b1100011}
- Range rule: legal only if in_imm[63:11] are all equal, i.e. a 12-bit signed value.
- Rejection: illegal type or out-of-range immediate.
  - The request is still accepted (handshake completes) but is not written to the FIFO.
  - Address counter is unchanged; err=1 for exactly the cycle after the accepting edge.
- Legal accept: at edge N, push {addr counter, word} and increment the counter (mod 2^ADDR_W; wraps to 0, not to BASE_ADDR). out_valid is high after edge N. Latency is 1 cycle; no combinational bypass.
- FIFO:
  - in_ready = !full. When full, no push occurs even if a pop happens in the same cycle.
  - Pop and push in the same cycle when neither full nor empty: both take effect, count unchanged.
  - Output order equals accept order.
- Reset mid-operation flushes all entries; buffered words are lost.

Optional Feature:
- Macro: ENC_SELF_CHECK_EN.
- Defined: each pushed word is re-decoded to a 64-bit sign-extended immediate using the ld/sd/br field layout and compared with in_imm. Any mismatch sets chk_fail, which holds until reset.
- Undefined: chk_fail is tied to 0 and no decode logic is built.

Decomposition:
- Package ins_enc_pkg:
  - type codes TYPE_LD/TYPE_SD/TYPE_BR/TYPE_ILL
  - opcodes OPC_LD/OPC_SD/OPC_BR
  - the FIFO entry struct {addr, ins}
- Sub-module ins_enc_fifo: parameterised sync FIFO with full/empty flags and pointer wrap; the encoder instantiates it.

Test Plan:
- ld rd=5, rs1=2, funct3=3, imm=64'hFFFF_FFFF_FFFF_FFF8 → out_ins=32'hFF813283, out_addr=0, out_valid one cycle after accept.
- sd rs2=7, rs1=3, funct3=3, imm=16 → out_ins=32'h0071B823, out_addr=1.
- br rs1=1, rs2=2, funct3=0, imm=4 → out_ins=32'h00208463; with ENC_SELF_CHECK_EN defined, chk_fail stays 0.
- ld imm=2048, then in_type=2'b10 → err pulses one cycle each; no output word; the next legal word gets the unchanged address.
- out_ready=0, six legal requests → in_ready low after the 4th accept; raise out_ready → addresses 0..5 emerge in order, no loss or duplication.
- ADDR_W=2 → 5th word has out_addr=0. Assert reset with 3 words buffered → out_valid=0 immediately, and the next word gets BASE_ADDR.
